// File: rtl/fifo_access_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : fifo_access_ctrl
// Purpose  : Debounces the board write/read buttons and turns each press into
//            a single guarded wReq/rReq pulse towards the FIFO.
// Options  : FIFO_CTRL_AUTOREPEAT_EN - a held read button re-fires every
//            REPEAT_CYCLES cycles.
// Revision : 1.0 - initial release
//==============================================================================
module fifo_access_ctrl #(
    parameter int WL            = 8,
    parameter int DEPTH         = 4,
    parameter int CW            = 3,
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          btn_wr,
    input  logic          btn_rd,
    input  logic [WL-1:0] sw,
    input  logic          full,
    input  logic          empty,
    input  logic [WL-1:0] fifo_dout,
    output logic          wReq,
    output logic          rReq,
    output logic [WL-1:0] din,
    output logic [WL-1:0] dout_hold,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          error
);

`ifdef FIFO_CTRL_AUTOREPEAT_EN
    localparam bit c_AUTOREPEAT = 1'b1;
`else
    localparam bit c_AUTOREPEAT = 1'b0;
`endif

    localparam int              c_DCW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_DCW-1:0] c_DEB_LAST = c_DCW'(DEB_CYCLES - 1);
    localparam int              c_RCW      = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_RCW-1:0] c_REP_LAST = c_RCW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0]    c_DEPTH    = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    logic [1:0]       w_btn_raw;
    logic [1:0]       w_lvl;
    logic [1:0]       w_rise;
    logic             w_wr_evt;
    logic             w_rd_evt;
    logic             w_rep_evt;
    logic [c_RCW-1:0] r_rep_cnt;

    state_t           r_state;
    logic             r_wr_pend;
    logic             r_rd_pend;
    logic [WL-1:0]    r_wr_data;

    assign w_btn_raw = {btn_rd, btn_wr};

    // Index 0 = write button, 1 = read button
    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic             r_s1;
        logic             r_s2;
        logic             r_lvl;
        logic             r_lvl_d;
        logic [c_DCW-1:0] r_cnt;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_btn_raw[g];
                r_s2    <= r_s1;
                r_lvl_d <= r_lvl;
                if (r_s2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_lvl <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DCW'(1);
                end
            end
        end

        assign w_lvl[g]  = r_lvl;
        assign w_rise[g] = r_lvl & ~r_lvl_d;
    end

    // Repeat timer restarts on every press and every repeat it generates
    always_ff @(posedge CLK) begin
        if (RST || !c_AUTOREPEAT || !w_lvl[1] || w_rise[1] || w_rep_evt) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + c_RCW'(1);
        end
    end

    assign w_rep_evt = c_AUTOREPEAT & w_lvl[1] & ~w_rise[1] & (r_rep_cnt == c_REP_LAST);
    assign w_wr_evt  = w_rise[0];
    assign w_rd_evt  = w_rise[1] | w_rep_evt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wr_data <= '0;
            wReq      <= 1'b0;
            rReq      <= 1'b0;
            din       <= '0;
            dout_hold <= '0;
            count     <= '0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            wReq <= 1'b0;
            rReq <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_wr_pend) begin
                        r_wr_pend <= 1'b0;
                        if (full) begin
                            error <= 1'b1;
                        end else begin
                            r_state <= S_WRITE;
                            wReq    <= 1'b1;
                            din     <= r_wr_data;
                            busy    <= 1'b1;
                            if (count < c_DEPTH) begin
                                count <= count + CW'(1);
                            end
                        end
                    end else if (r_rd_pend) begin
                        r_rd_pend <= 1'b0;
                        if (empty) begin
                            error <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            rReq    <= 1'b1;
                            busy    <= 1'b1;
                            if (count != '0) begin
                                count <= count - CW'(1);
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // FIFO read data is valid the cycle after rReq
                    dout_hold <= fifo_dout;
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
            // A fresh event outranks the clear above so it is never lost
            if (w_wr_evt) begin
                r_wr_pend <= 1'b1;
                r_wr_data <= sw;
            end
            if (w_rd_evt) begin
                r_rd_pend <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_fifo_access_ctrl
// Purpose  : Randomised + directed bench for fifo_access_ctrl with an
//            edge-timeline reference model and a small FIFO environment.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fifo_access_ctrl;

    localparam int WL            = 8;
    localparam int DEPTH         = 4;
    localparam int CW            = 3;
    localparam int DEB_CYCLES    = 4;
    localparam int REPEAT_CYCLES = 8;
`ifdef FIFO_CTRL_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          btn_wr = 1'b0;
    logic          btn_rd = 1'b0;
    logic [WL-1:0] sw = '0;
    logic          full = 1'b0;
    logic          empty = 1'b1;
    logic [WL-1:0] fifo_dout = '0;
    logic          wReq, rReq, busy, error;
    logic [WL-1:0] din, dout_hold;
    logic [CW-1:0] count;

    fifo_access_ctrl #(
        .WL(WL), .DEPTH(DEPTH), .CW(CW),
        .DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .CLK(CLK), .RST(RST), .btn_wr(btn_wr), .btn_rd(btn_rd), .sw(sw),
        .full(full), .empty(empty), .fifo_dout(fifo_dout),
        .wReq(wReq), .rReq(rReq), .din(din), .dout_hold(dout_hold),
        .count(count), .busy(busy), .error(error)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (edge timeline) ----------------
    // Edge e is the e-th rising clock edge; m_* are the outputs expected
    // during the cycle that follows edge e.
    int            e = 0;
    bit            hist [2][DEB_CYCLES+1];
    bit            lvl  [2];
    int            rise_e [2];
    bit            pend_w, pend_r;
    int            arm_w, arm_r;
    int            snap_e = -1, cap_e = -1, free_at = 0, busy_end = -1;
    logic [WL-1:0] wdata = '0, m_din = '0, m_hold = '0;
    int            m_cnt = 0;
    bit            m_wreq, m_rreq, m_busy, m_err;

    always @(posedge CLK) begin
        e = e + 1;
        if (RST) begin
            for (int b = 0; b < 2; b++) begin
                lvl[b] = 0;
                for (int j = 0; j <= DEB_CYCLES; j++) hist[b][j] = 0;
            end
            pend_w = 0; pend_r = 0; snap_e = -1; cap_e = -1;
            free_at = e + 1; busy_end = -1;
            wdata = '0; m_din = '0; m_hold = '0; m_cnt = 0;
            m_wreq = 0; m_rreq = 0; m_busy = 0; m_err = 0;
        end else begin
            m_wreq = 0;
            m_rreq = 0;
            if (e == cap_e)  m_hold = fifo_dout;
            if (e == snap_e) wdata  = sw;
            if (e >= free_at) begin
                if (pend_w && e >= arm_w) begin
                    pend_w = 0;
                    if (full) begin
                        m_err = 1; free_at = e + 1;
                    end else begin
                        m_wreq = 1; m_din = wdata;
                        if (m_cnt < DEPTH) m_cnt++;
                        busy_end = e; free_at = e + 2;
                    end
                end else if (pend_r && e >= arm_r) begin
                    pend_r = 0;
                    if (empty) begin
                        m_err = 1; free_at = e + 1;
                    end else begin
                        m_rreq = 1;
                        if (m_cnt > 0) m_cnt--;
                        busy_end = e + 1; cap_e = e + 2; free_at = e + 3;
                    end
                end
            end
            m_busy = (e <= busy_end);
            for (int b = 0; b < 2; b++) begin
                bit raw, flip, ev;
                raw  = (b == 0) ? btn_wr : btn_rd;
                flip = 1;
                // level moves once the synchronised value disagreed DEB_CYCLES edges in a row
                for (int j = 0; j < DEB_CYCLES; j++) if (hist[b][1+j] == lvl[b]) flip = 0;
                for (int j = DEB_CYCLES; j > 0; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = raw;
                ev = 0;
                if (flip) begin
                    lvl[b] = !lvl[b];
                    if (lvl[b]) begin ev = 1; rise_e[b] = e; end
                end else if (AUTOREP && b == 1 && lvl[b] && ((e - rise_e[b]) % REPEAT_CYCLES == 0)) begin
                    ev = 1;
                end
                if (ev) begin
                    if (b == 0) begin pend_w = 1; arm_w = e + 2; snap_e = e + 1; end
                    else        begin pend_r = 1; arm_r = e + 2; end
                end
            end
        end
    end

    // ---------------- compare + FIFO environment ----------------
    logic [WL-1:0] fq [$];
    bit force_nf = 0, force_ne = 0;
    bit prev_w = 0, prev_r = 0;
    int n_wp = 0, n_rp = 0, n_busy = 0, last_w_e = 0, last_r_e = 0;

    always @(negedge CLK) begin
        if (e > 0) begin
            cmp("wReq", wReq, m_wreq);
            cmp("rReq", rReq, m_rreq);
            cmp("busy", busy, m_busy);
            cmp("error", error, m_err);
            cmp("count", count, m_cnt);
            cmp("din", din, m_din);
            cmp("dout_hold", dout_hold, m_hold);
            cmp("req_exclusive", wReq & rReq, 0);
            cmp("wReq_one_cycle", wReq & prev_w, 0);
            cmp("rReq_one_cycle", rReq & prev_r, 0);
        end
        prev_w = wReq;
        prev_r = rReq;
        if (wReq === 1'b1) begin n_wp++; last_w_e = e; end
        if (rReq === 1'b1) begin n_rp++; last_r_e = e; end
        if (busy === 1'b1) n_busy++;
        if (!RST) begin
            if (wReq === 1'b1 && fq.size() < DEPTH) fq.push_back(din);
            if (rReq === 1'b1 && fq.size() > 0) fifo_dout = fq.pop_front();
        end
        full  = force_nf ? 1'b0 : (fq.size() == DEPTH);
        empty = force_ne ? 1'b0 : (fq.size() == 0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1; force_nf = 0; force_ne = 0; btn_wr = 0; btn_rd = 0;
        fq.delete();
        repeat (3) tick();
        RST = 0;
        tick();
    endtask

    task automatic press(input bit pw, input bit pr, input int nb, input int hold,
                         input int gap, input bit rnd_sw);
        for (int i = 0; i < nb; i++) begin
            btn_wr = pw & ~i[0];
            btn_rd = pr & ~i[0];
            if (rnd_sw) sw = WL'($urandom);
            tick();
        end
        btn_wr = pw;
        btn_rd = pr;
        for (int i = 0; i < hold; i++) begin
            if (rnd_sw) sw = WL'($urandom);
            tick();
        end
        btn_wr = 0;
        btn_rd = 0;
        for (int i = 0; i < gap; i++) begin
            if (rnd_sw) sw = WL'($urandom);
            tick();
        end
    endtask

    task automatic write_word(input logic [WL-1:0] v);
        sw = v;
        press(1, 0, 0, 6, 16, 0);
    endtask

    initial begin
        int w0, r0, b0;
        bit seen;
        do_reset();
        cmp("reset_wReq", wReq, 0);
        cmp("reset_rReq", rReq, 0);
        cmp("reset_din", din, 0);
        cmp("reset_dout_hold", dout_hold, 0);
        cmp("reset_count", count, 0);
        cmp("reset_busy", busy, 0);
        cmp("reset_error", error, 0);

        // read button bounce that never settles high
        r0 = n_rp;
        for (int i = 0; i < 10; i++) begin btn_rd = ~i[0]; tick(); end
        btn_rd = 0;
        repeat (12) tick();
        cmp("bounce_rd_pulses", n_rp - r0, 0);
        cmp("bounce_error", error, 0);

        // single clean write
        w0 = n_wp; b0 = n_busy;
        write_word(8'h2A);
        cmp("wr1_pulses", n_wp - w0, 1);
        cmp("wr1_din", din, 8'h2A);
        cmp("wr1_count", count, 1);
        cmp("wr1_busy_cycles", n_busy - b0, 1);

        // overflow attempt
        do_reset();
        w0 = n_wp;
        for (int i = 1; i <= 5; i++) write_word(WL'(i));
        cmp("ovf_pulses", n_wp - w0, 4);
        cmp("ovf_count", count, 4);
        cmp("ovf_error", error, 1);
        cmp("ovf_din", din, 8'h04);

        // two reads, then underflow
        do_reset();
        write_word(8'h11);
        write_word(8'h22);
        r0 = n_rp;
        press(0, 1, 0, 6, 16, 0);
        cmp("rd1_hold", dout_hold, 8'h11);
        press(0, 1, 0, 6, 16, 0);
        cmp("rd2_hold", dout_hold, 8'h22);
        cmp("rd2_count", count, 0);
        cmp("rd2_error", error, 0);
        press(0, 1, 0, 6, 16, 0);
        cmp("unf_rd_pulses", n_rp - r0, 2);
        cmp("unf_error", error, 1);

        // simultaneous write and read events
        do_reset();
        write_word(8'h5C);
        sw = 8'h77;
        press(1, 1, 0, 6, 20, 0);
        cmp("both_rd_after_wr", (last_r_e - last_w_e >= 2), 1);
        cmp("both_count", count, 1);
        cmp("both_hold", dout_hold, 8'h5C);

        // reset while in READ
        do_reset();
        write_word(8'h9D);
        btn_rd = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (rReq === 1'b1) seen = 1;
        end
        cmp("rst_read_reached", seen, 1);
        RST = 1;
        btn_rd = 0;
        fq.delete();
        tick();
        cmp("rst_mid_wReq", wReq, 0);
        cmp("rst_mid_rReq", rReq, 0);
        cmp("rst_mid_busy", busy, 0);
        cmp("rst_mid_din", din, 0);
        cmp("rst_mid_count", count, 0);
        RST = 0;
        repeat (16) tick();
        cmp("rst_mid_no_capture", dout_hold, 0);

        // occupancy counter saturation with flags forced open
        do_reset();
        force_nf = 1;
        for (int i = 0; i < 5; i++) write_word(WL'(8'hA0 + i));
        cmp("sat_hi_count", count, DEPTH);
        force_nf = 0;
        force_ne = 1;
        for (int i = 0; i < 5; i++) press(0, 1, 0, 6, 16, 0);
        cmp("sat_lo_count", count, 0);
        cmp("sat_error", error, 0);
        force_ne = 0;

        // held read button
        do_reset();
        for (int i = 0; i < 3; i++) write_word(WL'(8'h30 + i));
        r0 = n_rp;
        press(0, 1, 0, 30, 20, 0);
        if (AUTOREP) begin
            cmp("hold_rd_pulses", n_rp - r0, 3);
            cmp("hold_error", error, 1);
        end else begin
            cmp("hold_rd_pulses", n_rp - r0, 1);
            cmp("hold_error", error, 0);
        end

        // randomised traffic
        do_reset();
        for (int k = 0; k < 150; k++) begin
            int op;
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 19) == 0) do_reset();
            force_nf = ($urandom_range(0, 7) == 0);
            force_ne = ($urandom_range(0, 7) == 0);
            press(op != 1, op != 0, $urandom_range(0, 5), $urandom_range(5, 12), 16, 1);
        end
        force_nf = 0;
        force_ne = 0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
Sequencer between raw board buttons/switches and the FIFO instance. It synchronises and debounces the write/read buttons and converts each press into exactly one single-cycle wReq/rReq pulse. It guards the FIFO against overflow and underflow, tracks occupancy and holds the last popped word for the BCD display path. Sits beside FIFO in the top level, all on the same clock as the FIFO.

Parameters:
WL, 8, data word width
DEPTH, 4, FIFO depth; occupancy counter saturates here
CW, 3, occupancy counter width; must satisfy 2^CW > DEPTH
DEB_CYCLES, 4, consecutive stable cycles required to accept a debounced level change (set to ~1_000_000 on hardware)
REPEAT_CYCLES, 8, auto-repeat period; used only with the optional feature

Ports:
CLK  in  1  single clock, shared with FIFO
RST  in  1  synchronous, active-high reset
btn_wr  in  1  raw write button, asynchronous
btn_rd  in  1  raw read button, asynchronous
sw  in  WL  switch data to push
full  in  1  FIFO full flag
empty  in  1  FIFO empty flag
fifo_dout  in  WL  FIFO read data
wReq  out  1  one-cycle write request to FIFO
rReq  out  1  one-cycle read request to FIFO
din  out  WL  write data to FIFO, stable while wReq is high
dout_hold  out  WL  last word popped, for display
count  out  CW  controller-tracked occupancy, 0..DEPTH
busy  out  1  high in any state other than IDLE
error  out  1  sticky overflow/underflow attempt flag

Behaviour:
- Reset (sync, active-high): wReq=0, rReq=0, din=0, dout_hold=0, count=0, busy=0, error=0, state=IDLE. Sync flops, debounce counters and debounced levels all clear to 0. Reset asserted mid-operation aborts any pulse on the next edge, and no pending event survives.
- Input path: each button passes through a 2-flop synchroniser. The debounced level changes only after the synced value differs from the current level for DEB_CYCLES consecutive cycles; any bounce restarts the counter. A press event is a 0->1 change of the debounced level, one cycle wide.
- On a write event, sw is snapshotted into din. din holds until the next accepted write.
- Pending latches: wr_pend and rd_pend are set by events and cleared when the event is served or rejected.
- FSM states: IDLE, WRITE, READ, CAPTURE.
  - IDLE, wr_pend set: if full, set error, clear wr_pend, stay in IDLE. Otherwise go to WRITE.
  - IDLE, rd_pend set (and no wr_pend): if empty, set error, clear rd_pend, stay in IDLE. Otherwise go to READ.
  - Both pending: write is served first and read afterwards. Nothing is dropped.
  - WRITE: wReq=1 for exactly this one cycle; count+1; clear wr_pend; return to IDLE.
  - READ: rReq=1 for exactly this one cycle; count-1; clear rd_pend; go to CAPTURE.
  - CAPTURE: dout_hold <= fifo_dout (FIFO data is valid one cycle after rReq); return to IDLE.
- Latency:
  - Write: event at cycle t -> wReq high at t+2.
  - Read: event at cycle t -> rReq high at t+2 and dout_hold updated at t+4.
- Never assert wReq and rReq together. Never assert either for more than one cycle.
- count arithmetic:
  - count never exceeds DEPTH and never underflows.
  - The full/empty inputs are authoritative for gating.
  - count is informational only.
- error stays set until RST.

Optional Feature:
Macro FIFO_CTRL_AUTOREPEAT_EN.
- Defined: while the debounced read level stays high, an additional read event is generated every REPEAT_CYCLES cycles after the initial press. Repeat events follow the same empty-check rules, so holding the button on an empty FIFO sets error.
- Undefined: one press produces one read, and the REPEAT_CYCLES parameter is unused. Writes never auto-repeat in either build.

Test Plan:
- Bench setting DEB_CYCLES=4. btn_rd toggles 0/1 every cycle for 10 cycles then settles low -> no rReq, no events, error=0.
- Reset, sw=8'h2A, clean btn_wr press -> exactly one wReq pulse with din=8'h2A; count=1; busy high for 1 cycle.
- Write 4 words 8'h01..8'h04 then a 5th press with full=1 -> only 4 wReq pulses; count=4; error=1.
- Queue 8'h11 and 8'h22, then read twice -> 2 rReq pulses; dout_hold=8'h11 then 8'h22; count=0. A third read with empty=1 sets error=1 and produces no rReq.
- btn_wr and btn_rd events land on the same cycle with one word stored -> wReq precedes rReq with at least one cycle between them; count returns to 1.
- RST asserted on the cycle the FSM is in READ -> next cycle all outputs are 0 and state is IDLE. With FIFO_CTRL_AUTOREPEAT_EN defined, REPEAT_CYCLES=8 and 3 words stored, holding btn_rd for 30 cycles -> 3 rReq pulses spaced 8 cycles apart, then error=1.
